// File: rtl/lifo_pkg.sv
// Shared types and constants for the LIFO arbiter.
package lifo_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PUSH = 3'd1,
    POP  = 3'd2,
    WAIT = 3'd3,
    RESP = 3'd4
  } state_e;

  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;

  // Holds RD_LAT-1 for RD_LAT in 1..4.
  localparam int unsigned LAT_CNT_W = 2;

endpackage

// File: rtl/lifo_arbiter_rr_pick.sv
// Combinational round-robin select: first set request at or above ptr, wrapping.
module rr_pick #(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  grant_oh_c,
  output logic [IDX_W-1:0] grant_idx_c
);

  logic        found;
  int unsigned idx;

  // Scan NREQ positions starting at ptr; keep the first hit.
  always_comb begin
    grant_oh_c  = '0;
    grant_idx_c = '0;
    found       = 1'b0;
    idx         = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        found            = 1'b1;
        grant_oh_c[idx]  = 1'b1;
        grant_idx_c      = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/lifo_arbiter.sv
// Round-robin arbiter/sequencer sharing one LIFO stack between NREQ requesters.
module lifo_arbiter
  import lifo_pkg::*;
#(
  parameter int unsigned NREQ   = 2,
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_op,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic [NREQ-1:0]       rsp_valid,
  output logic                  rsp_err,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  lifo_wn,
  output logic                  lifo_rn,
  output logic [WIDTH-1:0]      lifo_din,
  input  logic [WIDTH-1:0]      lifo_dout,
  input  logic                  lifo_full,
  input  logic                  lifo_empty
);

  localparam int unsigned IDX_W = $clog2(NREQ);

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]       win_q, win_d;
  logic                   op_q, op_d;
  logic [WIDTH-1:0]       data_q, data_d;
  logic                   err_q, err_d;
  logic [LAT_CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]       rdata_q, rdata_d;

  logic                   lifo_wn_q, lifo_wn_d;
  logic                   lifo_rn_q, lifo_rn_d;
  logic [WIDTH-1:0]       lifo_din_q, lifo_din_d;
  logic [NREQ-1:0]        rsp_valid_q, rsp_valid_d;
  logic                   rsp_err_q, rsp_err_d;

  logic [NREQ-1:0]        pick_oh;
  logic [IDX_W-1:0]       pick_idx;

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req         (req_valid),
    .ptr         (rr_ptr_q),
    .grant_oh_c  (pick_oh),
    .grant_idx_c (pick_idx)
  );

  // Next-state, transaction latches and registered-output decode.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    win_d     = win_q;
    op_d      = op_q;
    data_d    = data_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    req_ready = '0;

    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          req_ready = pick_oh;
          win_d     = pick_idx;
          op_d      = req_op[pick_idx];
          data_d    = req_data[32'(pick_idx) * WIDTH +: WIDTH];
          err_d     = (req_op[pick_idx] == OP_POP) ? lifo_empty : lifo_full;
          rdata_d   = '0;
          if (err_d) begin
            state_d = RESP;
          end else if (op_d == OP_POP) begin
            state_d = POP;
          end else begin
            state_d = PUSH;
          end
        end
      end
      PUSH: begin
        state_d = RESP;
      end
      POP: begin
        cnt_d   = LAT_CNT_W'(RD_LAT - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          rdata_d = lifo_dout;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        rr_ptr_d = IDX_W'((32'(win_q) + 1) % NREQ);
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered copies of the decode of the next state.
    lifo_wn_d   = (state_d == PUSH);
    lifo_din_d  = lifo_wn_d ? data_d : '0;
    lifo_rn_d   = (state_d == POP);
    rsp_valid_d = (state_d == RESP) ? (NREQ'(1) << win_d) : '0;
    rsp_err_d   = (state_d == RESP) && err_d;
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      win_q       <= '0;
      op_q        <= OP_PUSH;
      data_q      <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      rdata_q     <= '0;
      lifo_wn_q   <= 1'b0;
      lifo_rn_q   <= 1'b0;
      lifo_din_q  <= '0;
      rsp_valid_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      win_q       <= win_d;
      op_q        <= op_d;
      data_q      <= data_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      lifo_wn_q   <= lifo_wn_d;
      lifo_rn_q   <= lifo_rn_d;
      lifo_din_q  <= lifo_din_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign lifo_wn   = lifo_wn_q;
  assign lifo_rn   = lifo_rn_q;
  assign lifo_din  = lifo_din_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_data  = rdata_q;

endmodule

// File: tb/tb_lifo_arbiter.sv
// Bench: two arbiter instances (RD_LAT 1 and 3), each with its own 8-deep stack model.
module tb_lifo_arbiter;

  localparam int unsigned NREQ  = 2;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 8;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic [1:0][NREQ-1:0]       req_valid = '0;
  logic [1:0][NREQ-1:0]       req_op    = '0;
  logic [1:0][NREQ*WIDTH-1:0] req_data  = '0;

  wire  [1:0][NREQ-1:0]       req_ready;
  wire  [1:0][NREQ-1:0]       rsp_valid;
  wire  [1:0]                 rsp_err;
  wire  [1:0][WIDTH-1:0]      rsp_data;
  wire  [1:0]                 lifo_wn;
  wire  [1:0]                 lifo_rn;
  wire  [1:0][WIDTH-1:0]      lifo_din;
  wire  [1:0][WIDTH-1:0]      lifo_dout;
  wire  [1:0]                 lifo_full;
  wire  [1:0]                 lifo_empty;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: plain stack contents and round-robin pointer per instance.
  logic [WIDTH-1:0] ref_stk [2][DEPTH];
  int               ref_n   [2];
  int               rr_ref  [2];
  int               lat_of  [2];

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int unsigned LAT = (g == 0) ? 1 : 3;

    logic [WIDTH-1:0] mem [DEPTH];
    int unsigned      sp = 0;
    logic [WIDTH-1:0] dl [LAT];

    assign lifo_full[g]  = (sp == DEPTH);
    assign lifo_empty[g] = (sp == 0);
    assign lifo_dout[g]  = dl[LAT-1];

    lifo_arbiter #(
      .NREQ   (NREQ),
      .WIDTH  (WIDTH),
      .RD_LAT (LAT)
    ) u_dut (
      .clock      (clock),
      .reset      (reset),
      .req_valid  (req_valid[g]),
      .req_op     (req_op[g]),
      .req_data   (req_data[g]),
      .req_ready  (req_ready[g]),
      .rsp_valid  (rsp_valid[g]),
      .rsp_err    (rsp_err[g]),
      .rsp_data   (rsp_data[g]),
      .lifo_wn    (lifo_wn[g]),
      .lifo_rn    (lifo_rn[g]),
      .lifo_din   (lifo_din[g]),
      .lifo_dout  (lifo_dout[g]),
      .lifo_full  (lifo_full[g]),
      .lifo_empty (lifo_empty[g])
    );

    // Stack: data appears on dout LAT-1 edges after the rn edge, junk otherwise.
    always @(posedge clock) begin
      if (lifo_wn[g] && sp < DEPTH) begin
        mem[sp] <= lifo_din[g];
        sp      <= sp + 1;
      end else if (lifo_rn[g] && sp > 0) begin
        sp <= sp - 1;
      end
      dl[0] <= (lifo_rn[g] && sp > 0) ? mem[sp-1] : 8'hEE;
      for (int k = 1; k < int'(LAT); k++) dl[k] <= dl[k-1];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One transaction: hold vmask until the response, check grant, timing, data and strobes.
  task automatic serve(input int inst, input logic [1:0] vmask, input logic [1:0] ops,
                       input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1);
    int               w;
    int               c;
    int               lat;
    int               exp_lat;
    int               nwn;
    int               nrn;
    bit               got;
    logic             eop;
    logic             eerr;
    logic [WIDTH-1:0] dpush;
    logic [WIDTH-1:0] edata;

    @(posedge clock); #1;
    req_valid[inst] = vmask;
    req_op[inst]    = ops;
    req_data[inst]  = {d1, d0};
    #1;

    w = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      c = (rr_ref[inst] + k) % NREQ;
      if (vmask[c]) w = c;
    end
    chk("grant", 32'(req_ready[inst]), 32'(1) << w);
    chk("idle_strobes", {30'd0, lifo_wn[inst], lifo_rn[inst]}, 32'd0);

    eop   = ops[w];
    dpush = (w == 0) ? d0 : d1;
    eerr  = eop ? (ref_n[inst] == 0) : (ref_n[inst] == DEPTH);
    edata = '0;
    if (!eerr) begin
      if (eop) begin
        ref_n[inst]--;
        edata = ref_stk[inst][ref_n[inst]];
      end else begin
        ref_stk[inst][ref_n[inst]] = dpush;
        ref_n[inst]++;
      end
    end
    exp_lat = eerr ? 1 : (eop ? 2 + lat_of[inst] : 2);

    nwn = 0;
    nrn = 0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 12) begin
      @(posedge clock); #2;
      lat++;
      chk("ready_busy", 32'(req_ready[inst]), 32'd0);
      chk("wn_rn_excl", 32'(lifo_wn[inst] & lifo_rn[inst]), 32'd0);
      if (lifo_wn[inst]) chk("din_val", 32'(lifo_din[inst]), 32'(dpush));
      else               chk("din_zero", 32'(lifo_din[inst]), 32'd0);
      nwn += int'(lifo_wn[inst]);
      nrn += int'(lifo_rn[inst]);
      if (rsp_valid[inst] != '0) got = 1'b1;
    end
    req_valid[inst] = '0;

    chk("rsp_latency", 32'(lat), 32'(exp_lat));
    chk("rsp_valid", 32'(rsp_valid[inst]), 32'(1) << w);
    chk("rsp_err", 32'(rsp_err[inst]), 32'(eerr));
    chk("rsp_data", 32'(rsp_data[inst]), 32'(edata));
    chk("wn_pulses", 32'(nwn), 32'(!eerr && !eop));
    chk("rn_pulses", 32'(nrn), 32'(!eerr && eop));
    rr_ref[inst] = (w + 1) % NREQ;
  endtask

  task automatic chk_outputs_zero(input string tag, input int inst);
    chk({tag, "_ready"}, 32'(req_ready[inst]), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid[inst]), 32'd0);
    chk({tag, "_rsp_err"}, 32'(rsp_err[inst]), 32'd0);
    chk({tag, "_rsp_data"}, 32'(rsp_data[inst]), 32'd0);
    chk({tag, "_strobes"}, {30'd0, lifo_wn[inst], lifo_rn[inst]}, 32'd0);
    chk({tag, "_din"}, 32'(lifo_din[inst]), 32'd0);
  endtask

  initial begin
    ref_n[0]  = 0;
    ref_n[1]  = 0;
    rr_ref[0] = 0;
    rr_ref[1] = 0;
    lat_of[0] = 1;
    lat_of[1] = 3;

    // Power-on reset.
    #12;
    chk_outputs_zero("por0", 0);
    chk_outputs_zero("por1", 1);
    #11 reset = 1'b1;

    // Reset in the middle of a pop: everything drops at once, no response.
    serve(0, 2'b01, 2'b00, 8'd55, 8'd0);
    @(posedge clock); #1;
    req_valid[0] = 2'b01;
    req_op[0]    = 2'b01;
    #1;
    chk("midpop_grant", 32'(req_ready[0]), 32'd1);
    @(posedge clock); #1;
    req_valid[0] = '0;
    #1;
    chk("midpop_rn", 32'(lifo_rn[0]), 32'd1);
    reset = 1'b0;
    #1;
    chk_outputs_zero("midpop_rst", 0);
    @(posedge clock); #3;
    reset     = 1'b1;
    rr_ref[0] = 0;
    rr_ref[1] = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #2;
      chk("idle_quiet", {28'd0, lifo_wn[0], lifo_rn[0], req_ready[0]}, 32'd0);
    end

    // Single requester LIFO order (55 stays from before the aborted pop).
    serve(0, 2'b01, 2'b00, 8'd100, 8'd0);
    serve(0, 2'b01, 2'b00, 8'd150, 8'd0);
    serve(0, 2'b01, 2'b00, 8'd200, 8'd0);
    for (int i = 0; i < 4; i++) serve(0, 2'b01, 2'b01, 8'd0, 8'd0);

    // Pop on empty.
    serve(0, 2'b01, 2'b01, 8'd0, 8'd0);
    #1 chk("empty_still", 32'(lifo_empty[0]), 32'd1);

    // Contention: requester 1 goes first alone so the pointer wraps back to 0.
    serve(0, 2'b10, 2'b00, 8'd0, 8'd22);
    for (int i = 0; i < 4; i++) serve(0, 2'b11, 2'b00, 8'd11, 8'd22);
    for (int i = 0; i < 4; i++) serve(0, 2'b11, 2'b11, 8'd0, 8'd0);

    // Fill to full, reject a ninth push, then pop the eighth value.
    for (int i = 0; i < 7; i++) serve(0, 2'b01, 2'b00, 8'(i + 1), 8'd0);
    serve(0, 2'b10, 2'b00, 8'd0, 8'd77);
    #1 chk("full_still", 32'(lifo_full[0]), 32'd1);
    serve(0, 2'b01, 2'b01, 8'd0, 8'd0);

    // Random traffic against the reference model.
    for (int i = 0; i < 80; i++)
      serve(0, 2'($urandom_range(1, 3)), 2'($urandom), 8'($urandom), 8'($urandom));

    // Longer read latency instance.
    serve(1, 2'b01, 2'b01, 8'd0, 8'd0);
    serve(1, 2'b01, 2'b00, 8'hA5, 8'd0);
    serve(1, 2'b10, 2'b00, 8'd0, 8'h5A);
    serve(1, 2'b11, 2'b11, 8'd0, 8'd0);
    serve(1, 2'b11, 2'b11, 8'd0, 8'd0);
    for (int i = 0; i < 40; i++)
      serve(1, 2'($urandom_range(1, 3)), 2'($urandom), 8'($urandom), 8'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
